// File: rtl/rotate_arbiter_if.sv
// Bundle of the two requester channels and the response channel of rotate_arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface rotate_arbiter_if #(
    parameter int N = 8
);
    localparam int S = $clog2(N);

    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [S-1:0] req0_b;
    logic         req0_dir;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [S-1:0] req1_b;
    logic         req1_dir;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_dir,
        output req1_valid, req1_a, req1_b, req1_dir,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_dir,
        input  req1_valid, req1_a, req1_b, req1_dir,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/rotate_arbiter.sv
// Two-requester round-robin front end sharing a single N-bit right rotator.
// Left rotates are performed as right rotates by (N-b) mod N.
module rotate_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    rotate_arbiter_if.slave bus
);
    localparam int S = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         last_q;
    logic [N-1:0] a_q;
    logic [S-1:0] b_q;
    logic         dir_q;
    logic         id_q;
    logic         rsp_valid_q;
    logic [N-1:0] rsp_data_q;
    logic         rsp_id_q;

    logic         grant0_s;
    logic         grant1_s;
    logic [S-1:0] amt_s;
    logic [S-1:0] lshift_s;
    logic [N-1:0] rot_s;

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst && (state_q == ST_IDLE)) begin
            grant0_s = bus.req0_valid && (!bus.req1_valid || last_q);
            grant1_s = bus.req1_valid && (!bus.req0_valid || !last_q);
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;

    // Shared right rotator; the S-bit wrap makes b=0 map to amount 0 for left too.
    always_comb begin
        amt_s    = dir_q ? ({S{1'b0}} - b_q) : b_q;
        lshift_s = {S{1'b0}} - amt_s;
        rot_s    = (a_q >> amt_s) | (a_q << lshift_s);
    end

    // Next-state logic of the IDLE -> CALC -> RESP sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0_s || grant1_s) begin
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured operands and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            a_q         <= {N{1'b0}};
            b_q         <= {S{1'b0}};
            dir_q       <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {N{1'b0}};
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == ST_RESP);
            if (grant0_s || grant1_s) begin
                a_q    <= grant1_s ? bus.req1_a   : bus.req0_a;
                b_q    <= grant1_s ? bus.req1_b   : bus.req0_b;
                dir_q  <= grant1_s ? bus.req1_dir : bus.req0_dir;
                id_q   <= grant1_s;
                last_q <= grant1_s;
            end
            if (state_q == ST_CALC) begin
                rsp_data_q <= rot_s;
                rsp_id_q   <= id_q;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_rotate_arbiter.sv
// Self-checking bench for rotate_arbiter: vector table, scoreboard of granted
// operations, and hand-written backpressure / reset corner sequences.
module tb_rotate_arbiter;
    localparam int N = 8;
    localparam int S = 3;

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [2:0] b;
        logic       dir;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    exp_t got_e;
    vec_t vecs[$];

    rotate_arbiter_if #(.N(N)) bus ();
    rotate_arbiter #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] rot_model(input logic [7:0] a, input logic [2:0] b, input logic dir);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (dir) r[(i + int'(b)) % N] = a[i];
            else     r[i] = a[(i + int'(b)) % N];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: push on observed grant, pop on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_ready || bus.req1_ready) begin
                check("one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
                if (bus.req1_ready) begin
                    mon_e.data = rot_model(bus.req1_a, bus.req1_b, bus.req1_dir);
                    mon_e.id   = 1'b1;
                end else begin
                    mon_e.data = rot_model(bus.req0_a, bus.req0_b, bus.req0_dir);
                    mon_e.id   = 1'b0;
                end
                sb_q.push_back(mon_e);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: response data %0h id %0d with nothing pending",
                             bus.rsp_data, bus.rsp_id);
                end else begin
                    got_e = sb_q.pop_front();
                    check("sb_data", 32'(bus.rsp_data), 32'(got_e.data));
                    check("sb_id", 32'(bus.rsp_id), 32'(got_e.id));
                end
            end
        end
    end

    task automatic drive_req(input logic id, input logic [7:0] a, input logic [2:0] b, input logic dir);
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_dir = dir; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_dir = dir; bus.req0_valid = 1'b1;
        end
    endtask

    // Called just after a rising edge; returns at the negedge where the grant is visible.
    task automatic wait_grant(input logic id, input string tag, output bit ok);
        int waited;
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < 20) begin
            @(negedge clk);
            waited++;
            ok = id ? bus.req1_ready : bus.req0_ready;
        end
        check({tag, "_grant_wait"}, 32'(waited), 32'd1);
        if (ok) check({tag, "_other_ready"}, 32'(id ? bus.req0_ready : bus.req1_ready), 32'd0);
    endtask

    task automatic run_op(input logic id, input logic [7:0] a, input logic [2:0] b,
                          input logic dir, input logic [7:0] exp, input string tag);
        bit ok;
        bus.rsp_ready = 1'b1;
        drive_req(id, a, b, dir);
        wait_grant(id, tag, ok);
        @(posedge clk); #2;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (ok) begin
            @(negedge clk);
            check({tag, "_calc_valid"}, 32'(bus.rsp_valid), 32'd0);
            check({tag, "_calc_ready"}, 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            @(negedge clk);
            check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp));
            check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(id));
            @(posedge clk); #2;
        end
    endtask

    initial begin
        bit ok;
        int got;
        logic [7:0] one;
        vec_t v;

        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 8'h11, 3'd1, 1'b0);
        drive_req(1'b1, 8'h22, 3'd2, 1'b1);

        // Reset state with both requesters already valid.
        repeat (2) @(negedge clk);
        check("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check("rst_ready1", 32'(bus.req1_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);

        // Continuous contention out of reset: grants must alternate 0,1,0,1.
        @(posedge clk); #2;
        rst = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                if (got == 0) check("rr_first_edge", 32'(cyc), 32'd0);
                check("rr_grant_id", 32'(bus.req1_ready), 32'(got % 2));
                got++;
            end
        end
        check("rr_grant_count", 32'(got), 32'd4);
        @(posedge clk); #2;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        // Vector table: spec examples, a few extras, exhaustive one-hot sweep.
        vecs.push_back('{1'b0, 8'hB4, 3'd3, 1'b0, 8'h96});
        vecs.push_back('{1'b1, 8'hB4, 3'd3, 1'b1, 8'hA5});
        vecs.push_back('{1'b0, 8'h5A, 3'd0, 1'b0, 8'h5A});
        vecs.push_back('{1'b1, 8'h5A, 3'd0, 1'b1, 8'h5A});
        vecs.push_back('{1'b0, 8'h81, 3'd1, 1'b1, 8'h03});
        vecs.push_back('{1'b1, 8'h81, 3'd1, 1'b0, 8'hC0});
        for (int b = 0; b < 8; b++) begin
            one = 8'h01;
            vecs.push_back('{b[0], 8'h01, 3'(b), 1'b0, one << ((8 - b) % 8)});
            vecs.push_back('{~b[0], 8'h01, 3'(b), 1'b1, one << b});
        end
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_op(v.id, v.a, v.b, v.dir, v.exp, $sformatf("vec%0d", i));
        end

        // Backpressure: response held for several cycles while req1 waits.
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 8'h3C, 3'd2, 1'b0);
        wait_grant(1'b0, "bp", ok);
        @(posedge clk); #2;
        bus.req0_valid = 1'b0;
        drive_req(1'b1, 8'h0F, 3'd4, 1'b1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_hold_data", 32'(bus.rsp_data), 32'h0F);
            check("bp_hold_id", 32'(bus.rsp_id), 32'd0);
            check("bp_hold_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            if (k < 5) @(negedge clk);
        end
        @(posedge clk); #2;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_ready1", 32'(bus.req1_ready), 32'd0);
        check("bp_hs_valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        check("bp_after_ready1", 32'(bus.req1_ready), 32'd1);
        check("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #2;
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_req1_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_req1_data", 32'(bus.rsp_data), 32'hF0);
        check("bp_req1_id", 32'(bus.rsp_id), 32'd1);
        @(posedge clk); #2;

        // Reset pulsed while an operation is in CALC: result must vanish.
        drive_req(1'b0, 8'hAA, 3'd1, 1'b0);
        wait_grant(1'b0, "rc", ok);
        @(posedge clk); #2;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("rc_calc_valid", 32'(bus.rsp_valid), 32'd0);
        #1;
        rst = 1'b1;
        sb_q.delete();
        drive_req(1'b1, 8'h96, 3'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rc_rst_valid", 32'(bus.rsp_valid), 32'd0);
            check("rc_rst_ready1", 32'(bus.req1_ready), 32'd0);
            check("rc_rst_data", 32'(bus.rsp_data), 32'd0);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        run_op(1'b1, 8'h96, 3'd3, 1'b1, 8'hB4, "rc_rel");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rc_no_stale", 32'(bus.rsp_valid), 32'd0);
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
